traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

- Demand-actuated, N-phase traffic signal controller that generalises the two-approach fixed-cycle controller.
- Adds:
  - parametrised phase count and durations,
  - an all-red clearance interval,
  - latched vehicle and pedestrian calls,
  - round-robin skipping of phases with no demand,
  - rest-in-green when nothing else is waiting.
- Sits between the intersection sensor/push-button conditioning logic and the lamp drivers.

## Interface
Parameters:
- N_PH, 4: number of phases (≥2).
- GREEN_T, 5: green duration in cycles (≥1).
- YELLOW_T, 2: yellow duration in cycles (≥1).
- ALLRED_T, 1: all-red clearance in cycles (≥1).
- PED_EXT, 3: extra green cycles granted when a pedestrian call is served (≥0).
- TW, 8: timer width. Must hold GREEN_T+PED_EXT−1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req  in  N_PH  vehicle call per phase. Single-cycle pulses suffice.
- ped_req  in  N_PH  pedestrian call per phase. Pulses suffice.
- lights  out  3*N_PH  per-phase {red,yellow,green}. Phase i occupies bits [3i+2:3i].
- walk  out  N_PH  walk indication per phase.
- phase  out  $clog2(N_PH)  index of the phase currently owning right-of-way.
- fsm_state  out  2  current state encoding, for debug/visibility.

## Operation
- States:
  - PH_GREEN: active phase green, all others red.
  - PH_YELLOW: active phase yellow, others red.
  - PH_ALLRED: all phases red.
- Transitions:
  - PH_GREEN→PH_YELLOW when the green time has expired and another phase has pending demand.
  - PH_YELLOW→PH_ALLRED after YELLOW_T cycles.
  - PH_ALLRED→PH_GREEN of the selected next phase after ALLRED_T cycles.
- Demand latches:
  - dem[i] and pdem[i] are set by req[i] and ped_req[i] respectively.
  - A call for the active phase is ignored while that phase is in PH_GREEN. It is latched during PH_YELLOW and PH_ALLRED.
  - Both latches for phase i clear on the cycle phase i enters PH_GREEN. A call for that phase arriving in that same cycle is absorbed, i.e. clear wins.
- Served-pedestrian flag: on green entry, ped_srv ← pdem[i] (pre-clear value).
  - Green length = GREEN_T + (ped_srv ? PED_EXT : 0).
  - walk[phase] = ped_srv during PH_GREEN; walk is 0 otherwise.
- Next-phase selection:
  - Made when green time expires.
  - Round-robin search from phase+1, wrapping modulo N_PH, picking the first j≠phase with dem[j]|pdem[j].
  - The result is registered as nxt and is not re-evaluated during yellow/all-red.
- Rest-in-green: if no other phase has demand at expiry, remain in PH_GREEN with the timer held at its terminal count. Demand is checked every cycle. Yellow starts on the cycle after demand is latched.
- Timer:
  - Cleared on every state entry.
  - Increments each cycle.
  - The state exits on the edge where timer == duration−1, so each state lasts exactly its duration in cycles.
- Outputs are Moore, decoded from registered state and phase:
  - red 3'b100, yellow 3'b010, green 3'b001.
  - No lamp field may ever be 3'b000 or multi-hot.

## Timing
- Reset values: state PH_GREEN, phase 0, timer 0, dem/pdem/ped_srv/nxt = 0, walk = 0, lights = phase 0 green, all others red, fsm_state = PH_GREEN.
- Reset has priority over all events. Assertion mid-cycle-sequence (any state) returns to the reset values on the next edge, and all latched demand is discarded.
- Call latency: a req pulse in cycle k is visible to the expiry decision in cycle k+1 at the earliest.
- Minimum phase-to-phase period: GREEN_T+YELLOW_T+ALLRED_T cycles.
- The walk edge coincides with the green lamp edge. Walk falls with the green-to-yellow edge.

## Structure
- Package traffic_pkg:
  - phase_state_t enum {PH_GREEN, PH_YELLOW, PH_ALLRED}.
  - Lamp constants LT_RED, LT_YEL, LT_GRN.
- Sub-module rr_phase_arbiter: combinational.
  - Inputs: a demand vector and the current index.
  - Outputs: a valid flag and the next index (first set bit after current, wrapping, excluding current).
- The FSM, timer, latches and decode live in traffic_phase_ctrl.

## Test plan
All scenarios use N_PH=4, GREEN_T=5, YELLOW_T=2, ALLRED_T=1, PED_EXT=3.
1. Reset, no calls for 50 cycles → lights = 12'b100_100_100_001 throughout, phase=0, walk=0.
2. req[2] pulsed in cycle 0 after reset →
   - phase 0 green cycles 0–4, yellow 5–6;
   - all-red cycle 7;
   - phase 2 green from cycle 8 (phase 1 skipped);
   - then rests in green.
3. req[1] and req[3] pulsed together → service order 0→1→3. Rests on 3. A later req[0] wraps the sequence back to 0.
4. ped_req[1] only →
   - phase 1 green lasts 8 cycles with walk[1]=1 for exactly those 8 cycles;
   - pdem[1] is cleared.
5. req[0] during phase 0 green is ignored. req[0] during yellow of phase 0 is latched and phase 0 is served again after the pending phase.
6. reset pulsed during PH_YELLOW with dem=4'b1010 → next cycle phase 0 green, dem=0, no further transitions without new calls.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the demand-actuated traffic controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_state_t;

  // Per-phase lamp field {red, yellow, green}; always exactly one-hot.
  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

endpackage

// File: rtl/rr_phase_arbiter.sv
// Combinational round-robin pick: nearest requesting phase after cur_i, wrapping, never cur_i itself.
module rr_phase_arbiter #(
  parameter int N_PH = 4,
  parameter int PW   = 2
) (
  input  logic [N_PH-1:0] dem_i,
  input  logic [PW-1:0]   cur_i,
  output logic            vld_o,
  output logic [PW-1:0]   idx_o
);

  int off;
  int best;

  always_comb begin
    vld_o = 1'b0;
    idx_o = cur_i;
    off   = 0;
    best  = N_PH;
    for (int i = 0; i < N_PH; i++) begin
      // Distance from the current phase in service order; 0 is the phase itself.
      off = (i - int'(cur_i) + N_PH) % N_PH;
      if (dem_i[i] && off != 0 && off < best) begin
        best  = off;
        vld_o = 1'b1;
        idx_o = PW'(i);
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase demand-actuated signal controller: green/yellow/all-red sequencing with latched
// vehicle and pedestrian calls, round-robin skipping of idle phases and rest-in-green.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_PH     = 4,
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int PED_EXT  = 3,
  parameter int TW       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PH-1:0]           req,
  input  logic [N_PH-1:0]           ped_req,
  output logic [3*N_PH-1:0]         lights,
  output logic [N_PH-1:0]           walk,
  output logic [$clog2(N_PH)-1:0]   phase,
  output logic [1:0]                fsm_state
);

  localparam int PW = $clog2(N_PH);

  phase_state_t    state_q;
  logic [PW-1:0]   phase_q;
  logic [PW-1:0]   nxt_q;
  logic [TW-1:0]   timer_q;
  logic [N_PH-1:0] dem_q, dem_d;
  logic [N_PH-1:0] pdem_q, pdem_d;
  logic            ped_srv_q;

  logic [N_PH-1:0] act_mask;
  logic [TW-1:0]   grn_last;
  logic            grn_entry;
  logic            arb_vld;
  logic [PW-1:0]   arb_idx;

  rr_phase_arbiter #(
    .N_PH (N_PH),
    .PW   (PW)
  ) u_arb (
    .dem_i (dem_q | pdem_q),
    .cur_i (phase_q),
    .vld_o (arb_vld),
    .idx_o (arb_idx)
  );

  always_comb begin
    act_mask = '0;
    if (state_q == PH_GREEN) act_mask[phase_q] = 1'b1;
    grn_last  = ped_srv_q ? TW'(GREEN_T + PED_EXT - 1) : TW'(GREEN_T - 1);
    grn_entry = (state_q == PH_ALLRED) && (timer_q == TW'(ALLRED_T - 1));

    // Calls for the phase currently in green are dropped; clearing on green entry beats a same-cycle call.
    dem_d  = dem_q  | (req     & ~act_mask);
    pdem_d = pdem_q | (ped_req & ~act_mask);
    if (grn_entry) begin
      dem_d[nxt_q]  = 1'b0;
      pdem_d[nxt_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PH_GREEN;
      phase_q   <= '0;
      nxt_q     <= '0;
      timer_q   <= '0;
      dem_q     <= '0;
      pdem_q    <= '0;
      ped_srv_q <= 1'b0;
    end else begin
      dem_q  <= dem_d;
      pdem_q <= pdem_d;
      case (state_q)
        PH_GREEN: begin
          if (timer_q == grn_last) begin
            // Terminal count: hold here (rest-in-green) until another phase calls.
            if (arb_vld) begin
              state_q <= PH_YELLOW;
              timer_q <= '0;
              nxt_q   <= arb_idx;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        PH_YELLOW: begin
          if (timer_q == TW'(YELLOW_T - 1)) begin
            state_q <= PH_ALLRED;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        PH_ALLRED: begin
          if (grn_entry) begin
            state_q   <= PH_GREEN;
            phase_q   <= nxt_q;
            timer_q   <= '0;
            ped_srv_q <= pdem_q[nxt_q];
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= PH_GREEN;
          timer_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    lights = '0;
    walk   = '0;
    for (int i = 0; i < N_PH; i++) begin
      lights[3*i +: 3] = LT_RED;
      if (PW'(i) == phase_q) begin
        if (state_q == PH_GREEN) begin
          lights[3*i +: 3] = LT_GRN;
          walk[i]          = ped_srv_q;
        end else if (state_q == PH_YELLOW) begin
          lights[3*i +: 3] = LT_YEL;
        end
      end
    end
  end

  assign phase     = phase_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with N_PH=4, GREEN_T=5, YELLOW_T=2, ALLRED_T=1, PED_EXT=3.
module tb_traffic_phase_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  ped_req;
  logic [11:0] lights;
  logic [3:0]  walk;
  logic [1:0]  phase;
  logic [1:0]  fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  localparam logic [11:0] ALLR = 12'b100_100_100_100;
  localparam logic [11:0] G0   = 12'b100_100_100_001;
  localparam logic [11:0] Y0   = 12'b100_100_100_010;
  localparam logic [11:0] G1   = 12'b100_100_001_100;
  localparam logic [11:0] Y1   = 12'b100_100_010_100;
  localparam logic [11:0] G2   = 12'b100_001_100_100;
  localparam logic [11:0] Y2   = 12'b100_010_100_100;
  localparam logic [11:0] G3   = 12'b001_100_100_100;
  localparam logic [11:0] Y3   = 12'b010_100_100_100;
  localparam logic [1:0]  SG = 2'd0, SY = 2'd1, SA = 2'd2;

  traffic_phase_ctrl #(
    .N_PH(4), .GREEN_T(5), .YELLOW_T(2), .ALLRED_T(1), .PED_EXT(3), .TW(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .ped_req   (ped_req),
    .lights    (lights),
    .walk      (walk),
    .phase     (phase),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_n, obs, exp);
    end
  endtask

  // Check one cycle at the falling edge, then advance; pulses set before the call last exactly one cycle.
  task automatic cyc(input string tag, input logic [11:0] el, input logic [1:0] ep,
                     input logic [3:0] ew, input logic [1:0] es);
    chk({tag, ".lights"}, 32'(lights), 32'(el));
    chk({tag, ".phase"}, 32'(phase), 32'(ep));
    chk({tag, ".walk"}, 32'(walk), 32'(ew));
    chk({tag, ".state"}, 32'(fsm_state), 32'(es));
    @(negedge clk);
    req     = '0;
    ped_req = '0;
    cyc_n++;
  endtask

  task automatic run(input string tag, input int n, input logic [11:0] el, input logic [1:0] ep,
                     input logic [3:0] ew, input logic [1:0] es);
    for (int k = 0; k < n; k++) cyc(tag, el, ep, ew, es);
  endtask

  // Leaves the bench at the falling edge of cycle 0 (reset values showing, reset now low).
  task automatic reset_dut();
    reset   = 1'b1;
    req     = '0;
    ped_req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc_n = 0;
  endtask

  initial begin
    // 1: idle rest on phase 0
    reset_dut();
    run("idle", 50, G0, 2'd0, 4'b0000, SG);

    // 2: req[2] skips phase 1, then rests on phase 2
    reset_dut();
    req = 4'b0100;
    run("skip.g0", 5, G0, 2'd0, 4'b0000, SG);
    run("skip.y0", 2, Y0, 2'd0, 4'b0000, SY);
    run("skip.ar", 1, ALLR, 2'd0, 4'b0000, SA);
    run("skip.g2", 12, G2, 2'd2, 4'b0000, SG);

    // 3: order 0->1->3, rest on 3, later req[0] wraps to 0
    reset_dut();
    req = 4'b1010;
    run("rr.g0", 5, G0, 2'd0, 4'b0000, SG);
    run("rr.y0", 2, Y0, 2'd0, 4'b0000, SY);
    run("rr.ar0", 1, ALLR, 2'd0, 4'b0000, SA);
    run("rr.g1", 5, G1, 2'd1, 4'b0000, SG);
    run("rr.y1", 2, Y1, 2'd1, 4'b0000, SY);
    run("rr.ar1", 1, ALLR, 2'd1, 4'b0000, SA);
    run("rr.g3", 7, G3, 2'd3, 4'b0000, SG);
    req = 4'b0001;
    run("rr.g3rest", 2, G3, 2'd3, 4'b0000, SG);
    run("rr.y3", 2, Y3, 2'd3, 4'b0000, SY);
    run("rr.ar3", 1, ALLR, 2'd3, 4'b0000, SA);
    run("rr.g0w", 6, G0, 2'd0, 4'b0000, SG);

    // 4: pedestrian call extends phase 1 green to 8 cycles with walk
    reset_dut();
    ped_req = 4'b0010;
    run("ped.g0", 5, G0, 2'd0, 4'b0000, SG);
    run("ped.y0", 2, Y0, 2'd0, 4'b0000, SY);
    run("ped.ar0", 1, ALLR, 2'd0, 4'b0000, SA);
    run("ped.g1", 1, G1, 2'd1, 4'b0010, SG);
    req = 4'b0001;
    run("ped.g1", 7, G1, 2'd1, 4'b0010, SG);
    run("ped.y1", 2, Y1, 2'd1, 4'b0000, SY);
    run("ped.ar1", 1, ALLR, 2'd1, 4'b0000, SA);
    run("ped.g0", 12, G0, 2'd0, 4'b0000, SG);

    // 5: own-phase call ignored in green, latched in yellow
    reset_dut();
    req = 4'b0001;
    cyc("own.g0", G0, 2'd0, 4'b0000, SG);
    req = 4'b0101;
    cyc("own.g0", G0, 2'd0, 4'b0000, SG);
    req = 4'b0001;
    run("own.g0", 3, G0, 2'd0, 4'b0000, SG);
    run("own.y0", 2, Y0, 2'd0, 4'b0000, SY);
    run("own.ar0", 1, ALLR, 2'd0, 4'b0000, SA);
    run("own.g2rest", 13, G2, 2'd2, 4'b0000, SG);
    req = 4'b0010;
    run("own.g2", 2, G2, 2'd2, 4'b0000, SG);
    req = 4'b0100;
    run("own.y2", 2, Y2, 2'd2, 4'b0000, SY);
    run("own.ar2", 1, ALLR, 2'd2, 4'b0000, SA);
    run("own.g1", 5, G1, 2'd1, 4'b0000, SG);
    run("own.y1", 2, Y1, 2'd1, 4'b0000, SY);
    run("own.ar1", 1, ALLR, 2'd1, 4'b0000, SA);
    run("own.g2again", 8, G2, 2'd2, 4'b0000, SG);

    // 6: reset in yellow discards latched demand
    reset_dut();
    req = 4'b1010;
    run("rst.g0", 5, G0, 2'd0, 4'b0000, SG);
    reset = 1'b1;
    cyc("rst.y0", Y0, 2'd0, 4'b0000, SY);
    reset = 1'b0;
    run("rst.after", 25, G0, 2'd0, 4'b0000, SG);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
